// File: rtl/lsu_sq_ring.sv
// lsu_sq_ring -- ordered circular store queue for the LSU.
//
// Holds issued stores in program order between head and tail pointers and
// retires them strictly from the head toward the D$/MSHQ. It also answers a
// registered store-to-load forwarding lookup: a load gets its data from the
// youngest older overlapping store, or is told to replay.
//
// Compile-time option:
//   LSU_SQ_FWD_EN  defined   -> full forwarding: hit/data/replay.
//                  undefined -> no forward data path. Hit and data are
//                               always 0. Replay is set on any older overlap.
//
// Ports:
//   clk, n_rst           clock; synchronous active-low reset
//   i_flush              discard all entries and any lookup in flight
//   o_full, o_empty      occupancy flags
//   o_tail_ptr           next allocation pointer (MSB = wrap bit)
//   i_alloc_*            allocation of one store per cycle
//   i_retire_*           ROB retire request plus D$/MSHQ status
//   o_retire_*           head entry contents, retire strobe, stall, tag error
//   i_lookup_*           load lookup request (address, byte mask, tail snapshot)
//   o_lookup_*           lookup result, one cycle after the request
//
// Retire handshake: i_retire_en is the request. o_retire_stall tells the ROB
// to hold the request. o_retire_en marks the cycle in which the head store is
// actually written and removed. A request while the queue is empty has no
// effect.
module lsu_sq_ring #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int SQ_DEPTH     = 8,
  parameter int SQ_IDX_WIDTH = $clog2(SQ_DEPTH)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_flush,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [SQ_IDX_WIDTH:0]     o_tail_ptr,
  input  logic                      i_alloc_en,
  input  logic [ADDR_WIDTH-1:0]     i_alloc_addr,
  input  logic [DATA_WIDTH-1:0]     i_alloc_data,
  input  logic [DATA_WIDTH/8-1:0]   i_alloc_width,
  input  logic [TAG_WIDTH-1:0]      i_alloc_tag,
  input  logic                      i_retire_en,
  input  logic [TAG_WIDTH-1:0]      i_retire_tag,
  input  logic                      i_retire_hit,
  input  logic                      i_retire_mshq_full,
  output logic                      o_retire_stall,
  output logic                      o_retire_en,
  output logic                      o_retire_hit,
  output logic [ADDR_WIDTH-1:0]     o_retire_addr,
  output logic [DATA_WIDTH-1:0]     o_retire_data,
  output logic [DATA_WIDTH/8-1:0]   o_retire_width,
  output logic                      o_retire_tag_err,
  input  logic                      i_lookup_en,
  input  logic [ADDR_WIDTH-1:0]     i_lookup_addr,
  input  logic [DATA_WIDTH/8-1:0]   i_lookup_width,
  input  logic [SQ_IDX_WIDTH:0]     i_lookup_ptr,
  output logic                      o_lookup_valid,
  output logic                      o_lookup_hit,
  output logic                      o_lookup_replay,
  output logic [DATA_WIDTH-1:0]     o_lookup_data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int PTR_W = SQ_IDX_WIDTH + 1;

  // Pointer and control state
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [SQ_DEPTH-1:0]     valid_q, valid_d;
  logic                    tag_err_q, tag_err_d;
  logic                    lk_valid_q, lk_valid_d;
  logic                    lk_hit_q, lk_hit_d;
  logic                    lk_replay_q, lk_replay_d;
  logic [DATA_WIDTH-1:0]   lk_data_q, lk_data_d;

  // Entry payloads (not reset)
  logic [ADDR_WIDTH-1:0]   addr_q  [SQ_DEPTH];
  logic [DATA_WIDTH-1:0]   data_q  [SQ_DEPTH];
  logic [BYTES-1:0]        width_q [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]    tag_q   [SQ_DEPTH];

  logic [SQ_IDX_WIDTH-1:0] head_idx, tail_idx;
  logic                    full, empty, retiring, alloc_upd, retire_upd;

  assign head_idx = head_q[SQ_IDX_WIDTH-1:0];
  assign tail_idx = tail_q[SQ_IDX_WIDTH-1:0];

  // Equal index bits with differing wrap bits means the ring is full.
  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[SQ_IDX_WIDTH] != tail_q[SQ_IDX_WIDTH]);

  assign o_full     = full;
  assign o_empty    = empty;
  assign o_tail_ptr = tail_q;

  assign o_retire_stall = i_retire_en && i_retire_mshq_full && !i_retire_hit;
  assign retiring       = i_retire_en && !o_retire_stall && !empty;
  assign o_retire_en    = retiring;
  assign o_retire_hit   = i_retire_hit;
  assign o_retire_addr  = addr_q[head_idx];
  assign o_retire_data  = data_q[head_idx];
  assign o_retire_width = width_q[head_idx];
  assign o_retire_tag_err = tag_err_q;

  // A flush overrides the alloc and retire state updates.
  assign alloc_upd  = i_alloc_en && !full && !i_flush;
  assign retire_upd = retiring && !i_flush;

  // ---------------------------------------------------------------------------
  // Lookup: scan entries by age (k = 0 is the head). An entry is older than
  // the load when its age is below the load's distance from the head. Using
  // ages instead of raw indices keeps the ordering correct across the wrap.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]        win_len;
  logic [SQ_IDX_WIDTH-1:0] e_idx [SQ_DEPTH];
  logic [SQ_DEPTH-1:0]     ov;

  always_comb begin
    win_len = i_lookup_ptr - head_q;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      e_idx[k] = head_idx + SQ_IDX_WIDTH'(k);
      ov[k]    = valid_q[e_idx[k]]
              && (PTR_W'(k) < win_len)
              && (addr_q[e_idx[k]][ADDR_WIDTH-1:OFF] == i_lookup_addr[ADDR_WIDTH-1:OFF])
              && (|(width_q[e_idx[k]] & i_lookup_width));
    end
  end

  logic                  fwd_hit, fwd_replay;
  logic [DATA_WIDTH-1:0] fwd_data;

`ifdef LSU_SQ_FWD_EN
  logic                  sel_found;
  logic [BYTES-1:0]      sel_mask;
  logic [DATA_WIDTH-1:0] sel_data;

  // The last match in age order is the youngest older store.
  always_comb begin
    sel_found = 1'b0;
    sel_mask  = '0;
    sel_data  = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      if (ov[k]) begin
        sel_found = 1'b1;
        sel_mask  = width_q[e_idx[k]];
        sel_data  = data_q[e_idx[k]];
      end
    end
  end

  always_comb begin
    fwd_hit    = sel_found && ((sel_mask & i_lookup_width) == i_lookup_width);
    fwd_replay = sel_found && !fwd_hit;
    fwd_data   = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (i_lookup_width[b]) fwd_data[8*b +: 8] = sel_data[8*b +: 8];
    end
    if (!fwd_hit) fwd_data = '0;
  end
`else
  assign fwd_hit    = 1'b0;
  assign fwd_replay = |ov;
  assign fwd_data   = '0;
`endif

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d      = head_q + {{SQ_IDX_WIDTH{1'b0}}, retire_upd};
    tail_d      = tail_q + {{SQ_IDX_WIDTH{1'b0}}, alloc_upd};
    valid_d     = valid_q;
    // A retire and an alloc in the same cycle never share an index: the ring
    // is neither empty nor full in that case.
    if (retire_upd) valid_d[head_idx] = 1'b0;
    if (alloc_upd)  valid_d[tail_idx] = 1'b1;
    // The tag check fires even when the retire is stalled.
    tag_err_d   = tag_err_q ||
                  (i_retire_en && !empty && !i_flush && (tag_q[head_idx] != i_retire_tag));
    lk_valid_d  = i_lookup_en && !i_flush;
    lk_hit_d    = lk_valid_d && fwd_hit;
    lk_replay_d = lk_valid_d && fwd_replay;
    lk_data_d   = lk_valid_d ? fwd_data : '0;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      tag_err_q   <= 1'b0;
      lk_valid_q  <= 1'b0;
      lk_hit_q    <= 1'b0;
      lk_replay_q <= 1'b0;
      lk_data_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      tag_err_q   <= tag_err_d;
      lk_valid_q  <= lk_valid_d;
      lk_hit_q    <= lk_hit_d;
      lk_replay_q <= lk_replay_d;
      lk_data_q   <= lk_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_upd) begin
      addr_q[tail_idx]  <= i_alloc_addr;
      data_q[tail_idx]  <= i_alloc_data;
      width_q[tail_idx] <= i_alloc_width;
      tag_q[tail_idx]   <= i_alloc_tag;
    end
  end

  assign o_lookup_valid  = lk_valid_q;
  assign o_lookup_hit    = lk_hit_q;
  assign o_lookup_replay = lk_replay_q;
  assign o_lookup_data   = lk_data_q;

endmodule

// File: tb/tb_lsu_sq_ring.sv
module tb_lsu_sq_ring;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 6;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic          i_flush, i_alloc_en, i_retire_en, i_retire_hit, i_retire_mshq_full, i_lookup_en;
  logic [AW-1:0] i_alloc_addr, i_lookup_addr;
  logic [DW-1:0] i_alloc_data;
  logic [3:0]    i_alloc_width, i_lookup_width;
  logic [TW-1:0] i_alloc_tag, i_retire_tag;
  logic [IW:0]   i_lookup_ptr;
  logic          o_full, o_empty, o_retire_stall, o_retire_en, o_retire_hit, o_retire_tag_err;
  logic [IW:0]   o_tail_ptr;
  logic [AW-1:0] o_retire_addr;
  logic [DW-1:0] o_retire_data, o_lookup_data;
  logic [3:0]    o_retire_width;
  logic          o_lookup_valid, o_lookup_hit, o_lookup_replay;

  lsu_sq_ring dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
    .o_full(o_full), .o_empty(o_empty), .o_tail_ptr(o_tail_ptr),
    .i_alloc_en(i_alloc_en), .i_alloc_addr(i_alloc_addr), .i_alloc_data(i_alloc_data),
    .i_alloc_width(i_alloc_width), .i_alloc_tag(i_alloc_tag),
    .i_retire_en(i_retire_en), .i_retire_tag(i_retire_tag), .i_retire_hit(i_retire_hit),
    .i_retire_mshq_full(i_retire_mshq_full), .o_retire_stall(o_retire_stall),
    .o_retire_en(o_retire_en), .o_retire_hit(o_retire_hit), .o_retire_addr(o_retire_addr),
    .o_retire_data(o_retire_data), .o_retire_width(o_retire_width),
    .o_retire_tag_err(o_retire_tag_err),
    .i_lookup_en(i_lookup_en), .i_lookup_addr(i_lookup_addr), .i_lookup_width(i_lookup_width),
    .i_lookup_ptr(i_lookup_ptr), .o_lookup_valid(o_lookup_valid), .o_lookup_hit(o_lookup_hit),
    .o_lookup_replay(o_lookup_replay), .o_lookup_data(o_lookup_data)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-ordered list of stores, each tagged with the
  // pointer value it was allocated at.
  typedef struct {
    logic [IW:0]   ptr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    mask;
    logic [TW-1:0] tag;
  } ent_t;

  ent_t        mq[$];
  logic [IW:0] m_head, m_tail;
  logic        m_err;
  // Expected lookup result per cycle: {valid, hit, replay, data}
  logic [DW+2:0] exp_q[$];

  function automatic logic [DW+2:0] model_lookup(logic [AW-1:0] la, logic [3:0] lm, logic [IW:0] lp);
    logic [IW:0] lim, age;
    logic found, hit;
    ent_t s;
    logic [DW-1:0] d;
    lim = lp - m_head;
    found = 1'b0;
    s = '{default: '0};
    foreach (mq[i]) begin
      age = mq[i].ptr - m_head;
      if (age < lim && mq[i].addr[AW-1:2] == la[AW-1:2] && (mq[i].mask & lm) != 0) begin
        found = 1'b1;
        s = mq[i];
      end
    end
`ifdef LSU_SQ_FWD_EN
    hit = found && ((s.mask & lm) == lm);
    d = '0;
    for (int b = 0; b < 4; b++) if (hit && lm[b]) d[8*b +: 8] = s.data[8*b +: 8];
    return {1'b1, hit, found && !hit, d};
`else
    hit = 1'b0;
    d = '0;
    return {1'b1, hit, found, d};
`endif
  endfunction

  // One cycle: check outputs for current inputs, then advance the model.
  task automatic tick();
    logic [IW:0] cnt;
    logic e_empty, e_full, e_stall, e_ret;
    logic [DW+2:0] e;
    @(negedge clk);
    cnt     = m_tail - m_head;
    e_empty = (cnt == 0);
    e_full  = (cnt == 4'd8);
    e_stall = i_retire_en && i_retire_mshq_full && !i_retire_hit;
    e_ret   = i_retire_en && !e_stall && !e_empty;
    check("full", o_full, e_full);
    check("empty", o_empty, e_empty);
    check("tail_ptr", o_tail_ptr, m_tail);
    check("stall", o_retire_stall, e_stall);
    check("retire_en", o_retire_en, e_ret);
    check("retire_hit", o_retire_hit, i_retire_hit);
    check("tag_err", o_retire_tag_err, m_err);
    if (!e_empty) begin
      check("retire_addr", o_retire_addr, mq[0].addr);
      check("retire_data", o_retire_data, mq[0].data);
      check("retire_width", o_retire_width, mq[0].mask);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("lk_valid", o_lookup_valid, e[DW+2]);
      if (e[DW+2]) begin
        check("lk_hit", o_lookup_hit, e[DW+1]);
        check("lk_replay", o_lookup_replay, e[DW]);
        check("lk_data", o_lookup_data, e[DW-1:0]);
      end
    end
    if (!i_flush && i_lookup_en) exp_q.push_back(model_lookup(i_lookup_addr, i_lookup_width, i_lookup_ptr));
    else exp_q.push_back('0);
    if (!i_flush && i_retire_en && !e_empty && mq[0].tag != i_retire_tag) m_err = 1'b1;
    if (i_flush) begin
      mq.delete();
      m_head = '0;
      m_tail = '0;
    end else begin
      if (e_ret) begin
        mq.delete(0);
        m_head = m_head + 1'b1;
      end
      if (i_alloc_en && !e_full) begin
        mq.push_back('{m_tail, i_alloc_addr, i_alloc_data, i_alloc_width, i_alloc_tag});
        m_tail = m_tail + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    i_alloc_en = 0; i_retire_en = 0; i_lookup_en = 0; i_flush = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_alloc(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m, input logic [TW-1:0] t);
    i_alloc_en = 1; i_alloc_addr = a; i_alloc_data = d; i_alloc_width = m; i_alloc_tag = t;
  endtask

  task automatic set_retire(input logic [TW-1:0] t, input logic hit, input logic mf);
    i_retire_en = 1; i_retire_tag = t; i_retire_hit = hit; i_retire_mshq_full = mf;
  endtask

  task automatic set_lookup(input logic [AW-1:0] a, input logic [3:0] m, input logic [IW:0] p);
    i_lookup_en = 1; i_lookup_addr = a; i_lookup_width = m; i_lookup_ptr = p;
  endtask

  logic [AW-1:0] pool [3];
  logic [IW:0]   p_store;
  logic [TW-1:0] tag_ctr;
  logic [IW:0]   cnt_r;

  initial begin
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;
    n_rst = 0; i_flush = 0; i_alloc_en = 0; i_retire_en = 0; i_lookup_en = 0;
    i_alloc_addr = '0; i_alloc_data = '0; i_alloc_width = '0; i_alloc_tag = '0;
    i_retire_tag = '0; i_retire_hit = 0; i_retire_mshq_full = 0;
    i_lookup_addr = '0; i_lookup_width = '0; i_lookup_ptr = '0;
    m_head = '0; m_tail = '0; m_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_full", o_full, 0);
    check("rst_empty", o_empty, 1);
    check("rst_tail", o_tail_ptr, 0);
    check("rst_retire_en", o_retire_en, 0);
    check("rst_stall", o_retire_stall, 0);
    check("rst_tag_err", o_retire_tag_err, 0);
    check("rst_lk", {o_lookup_valid, o_lookup_hit, o_lookup_replay}, 0);
    check("rst_lk_data", o_lookup_data, 0);
    @(posedge clk); #1;
    n_rst = 1;
    exp_q.push_back('0);

    // Fill with tags 0..7, then a rejected 9th alloc.
    for (int i = 0; i < 8; i++) begin
      set_alloc(32'h1000 + 4*i, $urandom, 4'hF, TW'(i));
      tick();
    end
    set_alloc(32'h2000, 32'hDEAD_BEEF, 4'hF, 6'd8);
    tick();
    check("full_after_8", o_full, 1);
    check("tail_after_8", o_tail_ptr, 4'b1000);

    // Stall with MSHQ full and a miss, then release.
    set_retire(6'd0, 0, 1);
    tick();
    set_retire(6'd0, 0, 0);
    tick();
    for (int i = 1; i < 8; i++) begin
      set_retire(TW'(i), 1, 0);
      tick();
    end
    check("empty_after_retire", o_empty, 1);
    check("no_tag_err", o_retire_tag_err, 0);

    // Forwarding from the youngest of two stores to the same word.
    set_alloc(32'h100, 32'hAAAA_AAAA, 4'hF, 6'd10); tick();
    set_alloc(32'h100, 32'hBBBB_BBBB, 4'hF, 6'd11); tick();
    set_lookup(32'h102, 4'hC, m_tail); tick();
`ifdef LSU_SQ_FWD_EN
    check("fwd_hit", o_lookup_hit, 1);
    check("fwd_data", o_lookup_data, 32'hBBBB_0000);
`else
    check("nofwd_replay", o_lookup_replay, 1);
    check("nofwd_hit", o_lookup_hit, 0);
`endif

    // Partial overlap replays; a load older than the store sees nothing.
    p_store = m_tail;
    set_alloc(32'h200, 32'h1234_5678, 4'h3, 6'd12); tick();
    set_lookup(32'h200, 4'hF, m_tail); tick();
    check("partial_replay", o_lookup_replay, 1);
    set_lookup(32'h200, 4'hF, p_store); tick();
    check("older_none", {o_lookup_valid, o_lookup_hit, o_lookup_replay}, 3'b100);

    // Wrap: restart from zero, fill, retire 5, alloc 5 across the wrap.
    i_flush = 1; tick();
    tag_ctr = '0;
    for (int i = 0; i < 8; i++) begin
      set_alloc(pool[$urandom_range(0, 2)], $urandom, 4'($urandom_range(1, 15)), tag_ctr);
      tag_ctr++;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_retire(mq[0].tag, 1, 0); tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_alloc(pool[$urandom_range(0, 2)], $urandom, 4'($urandom_range(1, 15)), tag_ctr);
      tag_ctr++;
      tick();
    end
    for (int i = 0; i < 24; i++) begin
      cnt_r = m_tail - m_head;
      set_lookup(pool[$urandom_range(0, 2)] + AW'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                 m_head + IW'(0) + (IW+1)'($urandom_range(0, int'(cnt_r))));
      tick();
    end
    // Flush with a lookup in flight.
    set_lookup(32'h100, 4'hF, m_tail); tick();
    i_flush = 1; set_lookup(32'h100, 4'hF, m_tail); tick();
    check("flush_lk_valid", o_lookup_valid, 0);
    check("flush_empty", o_empty, 1);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      cnt_r = m_tail - m_head;
      if ($urandom_range(0, 9) < 6) begin
        set_alloc(pool[$urandom_range(0, 2)], $urandom, 4'($urandom_range(1, 15)), tag_ctr);
        tag_ctr++;
      end
      if ($urandom_range(0, 1) == 1)
        set_retire((mq.size() != 0 && $urandom_range(0, 199) != 0) ? mq[0].tag : TW'($urandom),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) < 7)
        set_lookup(pool[$urandom_range(0, 2)] + AW'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                   m_head + (IW+1)'($urandom_range(0, int'(cnt_r))));
      i_flush = ($urandom_range(0, 63) == 0);
      tick();
    end
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_sq_ring.md
# lsu_sq_ring

Ordered, circular store queue for the LSU. It holds issued store ops in program order between a head and tail pointer and retires them strictly from the head into the D$/MSHQ path. It answers a registered store-to-load forwarding lookup so that loads can take data from the youngest older store, or be told to replay. It sits between LSU_ID (allocation), the ROB (retire) and the load pipeline (lookup).

## Interface
Parameters:
- DATA_WIDTH, 32, store/load data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, address width.
- TAG_WIDTH, 6, ROB tag width.
- SQ_DEPTH, 8, number of entries; power of 2, at least 2.
- SQ_IDX_WIDTH, $clog2(SQ_DEPTH), entry index width. Pointers are SQ_IDX_WIDTH+1 bits, with the MSB as the wrap bit.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, synchronous active-low.
- i_flush  in  1  discard all entries.
- o_full  out  1  all SQ_DEPTH entries are occupied.
- o_empty  out  1  no entries are occupied.
- o_tail_ptr  out  SQ_IDX_WIDTH+1  next allocation pointer; the load dispatch stage snapshots it.
- i_alloc_en  in  1  allocate a store.
- i_alloc_addr  in  ADDR_WIDTH  store address.
- i_alloc_data  in  DATA_WIDTH  store data, lane-aligned.
- i_alloc_width  in  DATA_WIDTH/8  byte-enable mask.
- i_alloc_tag  in  TAG_WIDTH  ROB tag.
- i_retire_en  in  1  ROB retires the oldest store.
- i_retire_tag  in  TAG_WIDTH  tag of the retiring store.
- i_retire_hit  in  1  D$ hit for the head store.
- i_retire_mshq_full  in  1  MSHQ cannot accept.
- o_retire_stall  out  1  ROB must hold the retire.
- o_retire_en  out  1  head store is being written this cycle.
- o_retire_hit  out  1  pass-through of i_retire_hit.
- o_retire_addr, o_retire_data, o_retire_width  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  contents of the head entry.
- o_retire_tag_err  out  1  sticky flag: i_retire_tag did not match the head tag.
- i_lookup_en  in  1  load lookup request.
- i_lookup_addr  in  ADDR_WIDTH  load address.
- i_lookup_width  in  DATA_WIDTH/8  load byte mask.
- i_lookup_ptr  in  SQ_IDX_WIDTH+1  o_tail_ptr value at load dispatch.
- o_lookup_valid, o_lookup_hit, o_lookup_replay  out  1  registered lookup result.
- o_lookup_data  out  DATA_WIDTH  forwarded data.

## Operation
- **Occupancy.** Count = tail − head, computed modulo 2^(SQ_IDX_WIDTH+1).
  - o_empty when head == tail.
  - o_full when the index bits are equal and the wrap bits differ.
- **Allocation.** When i_alloc_en && !o_full, write the entry at tail[SQ_IDX_WIDTH-1:0], set it valid and increment tail. Allocation while full is ignored.
- **Retire stall.** o_retire_stall = i_retire_en && i_retire_mshq_full && !i_retire_hit.
- **Retire.** retiring = i_retire_en && !o_retire_stall && !o_empty; o_retire_en = retiring.
  - On retire: clear the head entry's valid bit and increment head.
  - o_retire_addr/data/width are driven combinationally from the head entry.
- **Retire tag check.** If i_retire_en && !o_empty and the head tag differs from i_retire_tag, set o_retire_tag_err. The flag stays set until reset; the retire still proceeds.
- **Lookup window.** A lookup searches the "older" set: valid entries from head up to, but not including, i_lookup_ptr.
  - Word match: addresses are equal above bit $clog2(DATA_WIDTH/8).
  - Overlap: word match && (store mask & load mask) != 0.
  - The selected store is the youngest overlapping one, i.e. the one closest to i_lookup_ptr.
- **Lookup result.**
  - hit = 1: the selected store's mask covers the whole load mask. o_lookup_data = the selected store's data on the load lanes, 0 elsewhere.
  - replay = 1: the selected store overlaps only partially.
  - hit = replay = 0 with valid = 1: no overlap; the load uses the D$.
- **Flush.** i_flush sets head = tail = 0, clears all valid bits and drops any lookup in flight (o_lookup_valid = 0 the next cycle).
- **Priority.** Reset > flush > alloc/retire/lookup. Alloc and retire in the same cycle are both performed.

## Timing
- Reset values: o_full 0, o_empty 1, o_tail_ptr 0, o_retire_en 0, o_retire_stall 0, o_retire_tag_err 0, o_lookup_valid/hit/replay 0, o_lookup_data 0. Entry payloads are not reset.
- Allocation is visible to retire and lookup one cycle after i_alloc_en. A lookup in the same cycle as an allocation does not see the new store.
- A retire removes the entry at the clock edge. A lookup in the same cycle still sees the retiring entry.
- Lookup latency is 1 cycle: request at cycle N produces o_lookup_* at cycle N+1.
- When full, a retire in cycle N makes o_full 0 in cycle N+1; alloc in cycle N is still rejected.
- Pointer wrap: tail goes from SQ_DEPTH−1 with wrap 0 to 0 with wrap 1, and lookup age ordering must hold across the wrap.

## Configuration
- LSU_SQ_FWD_EN defined: full forwarding as described above.
- LSU_SQ_FWD_EN undefined:
  - The priority/forward data path is removed.
  - o_lookup_hit = 0 and o_lookup_data = 0.
  - o_lookup_replay = 1 if any older store overlaps.

## Test plan
- Reset then 8 allocs with tags 0..7 → o_full = 1 at cycle 9; a 9th alloc is ignored; o_tail_ptr = 4'b1000.
- Retire tags 0..7 with i_retire_hit = 1 → o_retire_addr follows program order; o_empty = 1 after the last one; o_retire_tag_err stays 0.
- Retire with i_retire_hit = 0 and i_retire_mshq_full = 1 → o_retire_stall = 1 and head is unchanged; deassert MSHQ full → retire completes.
- Two stores to 0x100, mask 0xF with data 0xAAAA_AAAA then 0xBBBB_BBBB; load 0x102, mask 0xC, ptr after both → next cycle hit = 1, data = 0xBBBB_0000. With LSU_SQ_FWD_EN off → replay = 1.
- Store 0x200 mask 0x3; load 0x200 mask 0xF → replay = 1. Load with ptr before that store → hit = replay = 0.
- Wrap: fill, retire 5, alloc 5 more, then look up across the wrap → the youngest older store is selected. Flush mid-lookup → o_lookup_valid = 0 and o_empty = 1.
